// File: rtl/arbitro_somador.sv
// Two requesters share one 16-bit ripple-carry adder through a 3-state FSM.
// Operands are registered on grant; the result is held until the owner takes it.
module arbitro_somador #(
  parameter bit PRIO_FIXO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        res0_valid,
  input  logic        res0_ready,
  output logic [15:0] res0_soma,
  output logic        res0_ovf,
  output logic        res1_valid,
  input  logic        res1_ready,
  output logic [15:0] res1_soma,
  output logic        res1_ovf,
  output logic        ocupado
);

  localparam int LARGURA = 16;

  typedef enum logic [1:0] {
    OCIOSO,
    CALC,
    ENTREGA
  } estado_t;

  estado_t              estado;
  estado_t              estado_prox;
  logic [LARGURA-1:0]   op_a;
  logic [LARGURA-1:0]   op_b;
  logic                 dono;
  logic                 ultimo;
  logic                 grant;
  logic                 aceita;
  logic                 entregue;
  logic [LARGURA-1:0]   soma;
  logic [LARGURA:0]     carry;
  logic                 ovf;

  // Ripple-carry adder with carry-in tied low; overflow compares the carries
  // into and out of the sign bit.
  always_comb begin
    // NOTE: every variable written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    soma     = '0;
    carry    = '0;
    carry[0] = 1'b0;
    for (int i = 0; i < LARGURA; i++) begin
      soma[i]    = op_a[i] ^ op_b[i] ^ carry[i];
      carry[i+1] = (op_a[i] & op_b[i]) | (carry[i] & (op_a[i] ^ op_b[i]));
    end
    ovf = carry[LARGURA-1] ^ carry[LARGURA];
  end

  // A tie goes to whoever was not served last, unless req0 has fixed priority.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = PRIO_FIXO ? 1'b0 : ~ultimo;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  always_comb begin
    estado_prox = estado;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    res0_valid  = 1'b0;
    res1_valid  = 1'b0;
    entregue    = 1'b0;
    case (estado)
      OCIOSO: begin
        req0_ready = req0_valid & ~grant;
        req1_ready = req1_valid &  grant;
        if (req0_valid || req1_valid) begin
          estado_prox = CALC;
        end
      end
      CALC: begin
        estado_prox = ENTREGA;
      end
      ENTREGA: begin
        res0_valid = ~dono;
        res1_valid =  dono;
        entregue   = dono ? res1_ready : res0_ready;
        if (entregue) begin
          estado_prox = OCIOSO;
        end
      end
      default: begin
        estado_prox = OCIOSO;
      end
    endcase
  end

  assign aceita  = req0_ready | req1_ready;
  assign ocupado = (estado != OCIOSO);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado <= OCIOSO;
    end else begin
      estado <= estado_prox;
    end
  end

  // NOTE: the operand and result registers are ordinary flops, not memories,
  // and are cleared by reset so the outputs are defined before first use.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a      <= '0;
      op_b      <= '0;
      dono      <= 1'b0;
      ultimo    <= 1'b1;
      res0_soma <= '0;
      res0_ovf  <= 1'b0;
      res1_soma <= '0;
      res1_ovf  <= 1'b0;
    end else begin
      if (aceita) begin
        op_a <= grant ? req1_a : req0_a;
        op_b <= grant ? req1_b : req0_b;
        dono <= grant;
      end
      // Only the owner's result register moves; the other keeps its last value.
      if (estado == CALC) begin
        if (dono) begin
          res1_soma <= soma;
          res1_ovf  <= ovf;
        end else begin
          res0_soma <= soma;
          res0_ovf  <= ovf;
        end
      end
      if (entregue) begin
        ultimo <= dono;
      end
    end
  end

endmodule

// File: tb/tb_arbitro_somador.sv
// Scoreboard bench for arbitro_somador: the driver queues expected results on
// acceptance, a monitor pops and compares on every result handshake.
module tb_arbitro_somador;

  typedef struct packed {
    logic        ch;
    logic [15:0] soma;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        res0_valid, res0_ready, res0_ovf;
  logic        res1_valid, res1_ready, res1_ovf;
  logic [15:0] res0_soma, res1_soma;
  logic        ocupado;

  logic        f_req0_valid, f_req0_ready, f_req1_valid, f_req1_ready;
  logic [15:0] f_req0_a, f_req0_b, f_req1_a, f_req1_b;
  logic        f_res0_valid, f_res0_ready, f_res0_ovf;
  logic        f_res1_valid, f_res1_ready, f_res1_ovf;
  logic [15:0] f_res0_soma, f_res1_soma;
  logic        f_ocupado;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  arbitro_somador #(.PRIO_FIXO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .res0_valid(res0_valid), .res0_ready(res0_ready), .res0_soma(res0_soma), .res0_ovf(res0_ovf),
    .res1_valid(res1_valid), .res1_ready(res1_ready), .res1_soma(res1_soma), .res1_ovf(res1_ovf),
    .ocupado(ocupado)
  );

  arbitro_somador #(.PRIO_FIXO(1'b1)) dut_fixo (
    .clk(clk), .rst(rst),
    .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_a(f_req0_a), .req0_b(f_req0_b),
    .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_a(f_req1_a), .req1_b(f_req1_b),
    .res0_valid(f_res0_valid), .res0_ready(f_res0_ready), .res0_soma(f_res0_soma), .res0_ovf(f_res0_ovf),
    .res1_valid(f_res1_valid), .res1_ready(f_res1_ready), .res1_soma(f_res1_soma), .res1_ovf(f_res1_ovf),
    .ocupado(f_ocupado)
  );

  task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", nome, got, exp);
    end
  endtask

  // Monitor: compares every result handshake against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (res0_valid && res1_valid) check("both_res_valid", 1, 0);
      if (res0_valid && res0_ready) begin
        if (exp_q.size() == 0) check("unexpected_res0", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("res0_channel", 0, {31'd0, e.ch});
          check("res0_soma", {16'd0, res0_soma}, {16'd0, e.soma});
          check("res0_ovf", {31'd0, res0_ovf}, {31'd0, e.ovf});
        end
      end
      if (res1_valid && res1_ready) begin
        if (exp_q.size() == 0) check("unexpected_res1", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("res1_channel", 1, {31'd0, e.ch});
          check("res1_soma", {16'd0, res1_soma}, {16'd0, e.soma});
          check("res1_ovf", {31'd0, res1_ovf}, {31'd0, e.ovf});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic ch, input logic [15:0] s, input logic o);
    exp_t e;
    e.ch = ch; e.soma = s; e.ovf = o;
    exp_q.push_back(e);
  endtask

  // Presents one request, waits (bounded) for acceptance, queues the expected
  // result and returns at the next falling edge with valid dropped.
  task automatic issue(input logic ch, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] es, input logic eo, output int espera);
    bit got;
    got = 0;
    espera = -1;
    @(negedge clk);
    if (ch) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    for (int n = 0; n < 20; n++) begin
      #1;
      if (ch ? req1_ready : req0_ready) begin got = 1; espera = n; break; end
      @(negedge clk);
    end
    check("accept_timeout", {31'd0, got}, 1);
    if (got) push_exp(ch, es, eo);
    @(negedge clk);
    if (ch) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit got;
    got = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      #1;
      if (!ocupado) begin got = 1; break; end
    end
    check("idle_timeout", {31'd0, got}, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outputs"},
          {19'd0, req0_ready, req1_ready, res0_valid, res1_valid, res0_ovf, res1_ovf, ocupado,
           f_req0_ready, f_req1_ready, f_res0_valid, f_res1_valid, f_ocupado}, 0);
    check({tag, "_somas"}, {res0_soma, res1_soma}, 0);
  endtask

  initial begin
    int   w;
    bit   got;
    logic g;
    logic [15:0] va   [5] = '{16'h7FFF, 16'hFFFF, 16'h8000, 16'h4000, 16'hFFFF};
    logic [15:0] vb   [5] = '{16'h0001, 16'h0001, 16'h8000, 16'h4000, 16'hFFFF};
    logic [15:0] vs   [5] = '{16'h8000, 16'h0000, 16'h0000, 16'h8000, 16'hFFFE};
    logic        vo   [5] = '{1'b1,     1'b0,     1'b1,     1'b1,     1'b0};
    logic        vch  [5] = '{1'b0,     1'b0,     1'b0,     1'b1,     1'b1};
    logic        rr_g [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req1_valid = 0; req1_a = 0; req1_b = 0;
    res0_ready = 0; res1_ready = 1;
    f_req0_valid = 0; f_req0_a = 0; f_req0_b = 0; f_req1_valid = 0; f_req1_a = 0; f_req1_b = 0;
    f_res0_ready = 1; f_res1_ready = 1;
    @(negedge clk); @(negedge clk); #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Basic add with latency: ready in the presenting cycle, result two edges later.
    issue(1'b0, 16'h0003, 16'h0004, 16'h0007, 1'b0, w);
    check("t2_ready_same_cycle", w, 0);
    #1;
    check("t2_calc_no_valid", {31'd0, res0_valid}, 0);
    check("t2_calc_ocupado", {31'd0, ocupado}, 1);
    @(negedge clk); #1;
    check("t2_res_valid", {31'd0, res0_valid}, 1);
    @(negedge clk);
    res0_ready = 1'b1;
    wait_idle();

    // Overflow boundary vectors on both channels.
    for (int i = 0; i < 5; i++) begin
      issue(vch[i], va[i], vb[i], vs[i], vo[i], w);
      wait_idle();
    end

    // Reset while a result is being held.
    res0_ready = 1'b0;
    issue(1'b0, 16'h1111, 16'h2222, 16'h3333, 1'b0, w);
    @(negedge clk); #1;
    check("t1_held_valid", {31'd0, res0_valid}, 1);
    check("t1_held_soma", {16'd0, res0_soma}, 32'h3333);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_all_zero("midrun_reset");
    @(negedge clk);
    rst = 1'b0;
    res0_ready = 1'b1;

    // Round-robin with both requesters always valid; reset left ultimo = 1.
    @(negedge clk);
    req0_valid = 1; req0_a = 16'h0001; req0_b = 16'h0001;
    req1_valid = 1; req1_a = 16'h0010; req1_b = 16'h0020;
    for (int k = 0; k < 4; k++) begin
      got = 0;
      for (int n = 0; n < 20; n++) begin
        #1;
        if (req0_ready || req1_ready) begin got = 1; break; end
        @(negedge clk);
      end
      check("rr_timeout", {31'd0, got}, 1);
      check("rr_single_ready", {31'd0, req0_ready & req1_ready}, 0);
      g = req1_ready;
      check($sformatf("rr_grant_%0d", k), {31'd0, g}, {31'd0, rr_g[k]});
      if (got) begin
        if (g) push_exp(1'b1, 16'h0030, 1'b0);
        else   push_exp(1'b0, 16'h0002, 1'b0);
      end
      @(negedge clk);
    end
    req0_valid = 0; req1_valid = 0;
    wait_idle();

    // Fixed priority instance: req0 always wins a tie.
    @(negedge clk);
    f_req0_valid = 1; f_req0_a = 16'h0002; f_req0_b = 16'h0003;
    f_req1_valid = 1; f_req1_a = 16'h0004; f_req1_b = 16'h0005;
    for (int k = 0; k < 4; k++) begin
      got = 0;
      for (int n = 0; n < 20; n++) begin
        #1;
        if (f_req0_ready || f_req1_ready) begin got = 1; break; end
        @(negedge clk);
      end
      check("fixo_timeout", {31'd0, got}, 1);
      check($sformatf("fixo_grant_%0d", k), {31'd0, f_req1_ready}, 0);
      @(negedge clk);
      if (k == 0) begin
        @(negedge clk); #1;
        check("fixo_soma", {f_res0_valid, 15'd0, f_res0_soma}, {1'b1, 15'd0, 16'h0005});
        @(negedge clk);
      end
    end
    f_req0_valid = 0; f_req1_valid = 0;
    repeat (4) @(negedge clk);

    // Back-pressure on res0 while req1 waits.
    res0_ready = 1'b0;
    issue(1'b0, 16'h1234, 16'h1111, 16'h2345, 1'b0, w);
    req1_valid = 1; req1_a = 16'h0100; req1_b = 16'h00FF;
    @(negedge clk);
    for (int n = 0; n < 5; n++) begin
      #1;
      check("t5_hold_state",
            {28'd0, res0_valid, res1_valid, ocupado, req1_ready}, {28'd0, 4'b1010});
      check("t5_hold_soma", {16'd0, res0_soma}, 32'h2345);
      @(negedge clk);
    end
    res0_ready = 1'b1;
    @(negedge clk); #1;
    check("t5_req1_granted", {30'd0, req1_ready, ocupado}, {30'd0, 2'b10});
    if (req1_ready) push_exp(1'b1, 16'h01FF, 1'b0);
    @(negedge clk);
    req1_valid = 0;
    wait_idle();

    // Reset during CALC: that operation must never produce a result.
    issue(1'b0, 16'h0005, 16'h0006, 16'h000B, 1'b0, w);
    #1;
    check("t6_in_calc", {31'd0, ocupado}, 1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("t6_reset_ocupado", {31'd0, ocupado}, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk); #1;
      check("t6_no_result", {30'd0, res0_valid, res1_valid}, 0);
    end
    issue(1'b0, 16'h0020, 16'h0022, 16'h0042, 1'b0, w);
    wait_idle();

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
